// File: rtl/bch73_lfsr_encoder_if.sv
// Message-in / codeword-out handshake bundle for bch73_lfsr_encoder.
// Both channels are valid/ready: a transfer happens on a rising clk edge where valid and ready are both high; valid never waits for ready and payload holds until the transfer.
interface bch73_lfsr_encoder_if #(
  parameter int MSG_W = 37,
  parameter int PAR_W = 36
);
  logic                   in_valid;
  logic                   in_ready;
  logic [MSG_W-1:0]       msg_in;
  logic                   out_valid;
  logic                   out_ready;
  logic [MSG_W+PAR_W-1:0] codeword_out;

  modport master (
    output in_valid, msg_in, out_ready,
    input  in_ready, out_valid, codeword_out
  );

  modport slave (
    input  in_valid, msg_in, out_ready,
    output in_ready, out_valid, codeword_out
  );
endinterface

// File: rtl/bch73_lfsr_encoder.sv
// Systematic bit-serial (73,37) cyclic encoder: one message bit per clock into a parity LFSR, codeword {msg, parity}.
// Optional macro ERR_INJ_EN adds inj_en/inj_pos_a/inj_pos_b to flip up to two codeword bits for decoder testing.
module bch73_lfsr_encoder #(
  parameter int               MSG_W    = 37,
  parameter int               PAR_W    = 36,
  parameter logic [PAR_W-1:0] GEN_POLY = 36'h5D37FD975,
  parameter int               CNT_W    = 6
) (
  input  logic                       clk,
  input  logic                       rst,
  bch73_lfsr_encoder_if.slave        bus,
`ifdef ERR_INJ_EN
  input  logic                       inj_en,
  input  logic [6:0]                 inj_pos_a,
  input  logic [6:0]                 inj_pos_b,
`endif
  output logic                       busy,
  output logic [1:0]                 state_dbg
);

  localparam int CW_W = MSG_W + PAR_W;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic [MSG_W-1:0]    msg_q;
  logic [PAR_W-1:0]    rem_q;
  logic [PAR_W-1:0]    rem_next;
  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    bit_idx;
  logic [CW_W-1:0]     cw_q;
  logic [CW_W-1:0]     inj_mask;
  logic                msg_bit;
  logic                fb;
  logic                last_bit;
  logic                accept;
  logic                in_ready_c;
  logic                out_valid_c;
  logic                busy_c;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // ---------------- FSM: next-state logic ----------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (bus.in_valid)  state_d = S_SHIFT;
      S_SHIFT: if (last_bit)      state_d = S_DONE;
      S_DONE:  if (bus.out_ready) state_d = S_IDLE;
      default:                    state_d = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    busy_c      = 1'b0;
    unique case (state_q)
      S_IDLE:  in_ready_c  = 1'b1;
      S_SHIFT: busy_c      = 1'b1;
      S_DONE: begin
        out_valid_c = 1'b1;
        busy_c      = 1'b1;
      end
      default: in_ready_c  = 1'b0;
    endcase
  end

  assign bus.in_ready     = in_ready_c;
  assign bus.out_valid    = out_valid_c;
  assign bus.codeword_out = cw_q;
  assign busy             = busy_c;
  assign state_dbg        = state_q;

  assign accept   = bus.in_valid && in_ready_c;
  assign last_bit = (state_q == S_SHIFT) && (cnt_q == CNT_W'(MSG_W - 1));

  // Message is consumed MSB first; the counter only reaches MSG_W-1, so the index never underflows.
  assign bit_idx  = CNT_W'(MSG_W - 1) - cnt_q;
  assign msg_bit  = msg_q[bit_idx];
  assign fb       = msg_bit ^ rem_q[PAR_W-1];
  assign rem_next = {rem_q[PAR_W-2:0], 1'b0} ^ (fb ? GEN_POLY : '0);

`ifdef ERR_INJ_EN
  logic       inj_en_q;
  logic [6:0] inj_pos_a_q;
  logic [6:0] inj_pos_b_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inj_en_q    <= 1'b0;
      inj_pos_a_q <= '0;
      inj_pos_b_q <= '0;
    end else if (accept) begin
      inj_en_q    <= inj_en;
      inj_pos_a_q <= inj_pos_a;
      inj_pos_b_q <= inj_pos_b;
    end
  end

  // XOR of the two one-hot hits: equal positions cancel, positions >= CW_W never match.
  always_comb begin
    inj_mask = '0;
    for (int i = 0; i < CW_W; i++) begin
      inj_mask[i] = inj_en_q && ((inj_pos_a_q == 7'(i)) ^ (inj_pos_b_q == 7'(i)));
    end
  end
`else
  assign inj_mask = '0;
`endif

  // ---------------- datapath ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      msg_q <= '0;
      rem_q <= '0;
      cnt_q <= '0;
      cw_q  <= '0;
    end else if (accept) begin
      msg_q <= bus.msg_in;
      rem_q <= '0;
      cnt_q <= '0;
    end else if (state_q == S_SHIFT) begin
      rem_q <= rem_next;
      cnt_q <= cnt_q + CNT_W'(1);
      // Codeword is captured with the final remainder so it is stable for the whole DONE phase.
      if (last_bit) cw_q <= {msg_q, rem_next} ^ inj_mask;
    end
  end

endmodule
